// File: rtl/gray_code_converter_pipe.sv
// gray_code_converter_pipe
//
// Pipelined, bidirectional Gray/binary converter with a valid/ready handshake.
// It sits beside the async FIFO pointer logic. Each transaction picks its own
// direction. Gray inputs are also step-checked against the previous accepted
// Gray input. A jump of more than one bit flags a corrupted synchronised
// pointer.
//
// Parameters:
//   WIDTH    code width in bits (2..32)
//   STAGES   pipeline register stages, equal to the latency in cycles (1..4)
//   ERRCNT_W width of the saturating violation counter
//
// Ports:
//   clk        clock, all logic on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   input transaction present
//   in_ready   converter can accept this cycle (forced 0 while in reset)
//   in_mode    0 = Gray-to-binary, 1 = binary-to-Gray
//   in_data    code to convert
//   chk_clr    clears the step-check history and the error counter
//   out_valid  result present
//   out_ready  downstream accepts result
//   out_data   converted code
//   out_mode   in_mode carried alongside the result
//   out_err    step-check violation flag for this result
//   err_cnt    saturating count of violations
module gray_code_converter_pipe #(
    parameter int WIDTH    = 6,
    parameter int STAGES   = 2,
    parameter int ERRCNT_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_mode,
    input  logic [WIDTH-1:0]    in_data,
    input  logic                chk_clr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_mode,
    output logic                out_err,
    output logic [ERRCNT_W-1:0] err_cnt
);

    logic [STAGES-1:0] v;
    logic [WIDTH-1:0]  d [STAGES];
    logic [STAGES-1:0] m;
    logic [STAGES-1:0] e;

    logic [STAGES-1:0] ld;
    logic              acc;

    logic [WIDTH-1:0]  last_gray;
    logic              has_last;

    logic [WIDTH-1:0]  g2b;
    logic [WIDTH-1:0]  conv;
    logic [WIDTH-1:0]  diff;
    logic              multi_bit;
    logic              viol;

    // Stage i can load when any stage from i to the output is empty, or when
    // the output is being consumed. In either case the whole occupied run ahead
    // of stage i shifts forward. Writing it in flattened form avoids a
    // combinational self-reference in the ready chain.
    for (genvar i = 0; i < STAGES; i++) begin : g_ld
        assign ld[i] = out_ready || !(&v[STAGES-1:i]);
    end

    assign in_ready = rst_n && ld[0];
    assign acc      = in_valid && in_ready;

    // Gray-to-binary: bit k is the XOR of all Gray bits at or above k. The
    // result is the XOR of every right-shift of the input.
    always_comb begin
        g2b = in_data;
        for (int s = 1; s < WIDTH; s++) begin
            g2b = g2b ^ (in_data >> s);
        end
    end

    assign conv = in_mode ? (in_data ^ (in_data >> 1)) : g2b;

    // More than one differing bit means clearing the lowest set bit leaves
    // something behind.
    assign diff      = in_data ^ last_gray;
    assign multi_bit = |(diff & (diff - WIDTH'(1)));
    assign viol      = !in_mode && has_last && multi_bit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v         <= '0;
            m         <= '0;
            e         <= '0;
            for (int i = 0; i < STAGES; i++) begin
                d[i] <= '0;
            end
            last_gray <= '0;
            has_last  <= 1'b0;
            err_cnt   <= '0;
        end else begin
            if (ld[0]) begin
                v[0] <= acc;
                if (acc) begin
                    d[0] <= conv;
                    m[0] <= in_mode;
                    e[0] <= viol;
                end
            end
            for (int i = 1; i < STAGES; i++) begin
                if (ld[i]) begin
                    v[i] <= v[i-1];
                    if (v[i-1]) begin
                        d[i] <= d[i-1];
                        m[i] <= m[i-1];
                        e[i] <= e[i-1];
                    end
                end
            end

            // A clear that coincides with an accepted Gray input still
            // checks that input against the old history. The history is then
            // reloaded from that input.
            if (acc && !in_mode) begin
                last_gray <= in_data;
                has_last  <= 1'b1;
            end else if (chk_clr) begin
                has_last  <= 1'b0;
            end

            if (chk_clr) begin
                err_cnt <= '0;
            end else if (acc && viol && (err_cnt != {ERRCNT_W{1'b1}})) begin
                err_cnt <= err_cnt + ERRCNT_W'(1);
            end
        end
    end

    assign out_valid = v[STAGES-1];
    assign out_data  = d[STAGES-1];
    assign out_mode  = m[STAGES-1];
    assign out_err   = e[STAGES-1];

endmodule
